// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial add/subtract unit, BPC bits per clock, LSB first; optional accumulator under SERIAL_ADDER_ACCUM_EN
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
`ifdef SERIAL_ADDER_ACCUM_EN
    ,
    input  logic             acc_clr
`endif
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Reject parameter sets that cannot be processed in whole digits.
    generate
        if (BPC < 1 || WIDTH < 2 || (WIDTH % BPC) != 0) begin : g_bad_params
            $error("serial_adder: BPC must be >= 1 and divide WIDTH, WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] res_reg;
    logic             carry;
    logic [CW-1:0]    count;

    logic [BPC-1:0]   slice_sum;
    logic [BPC:0]     slice_c;
    logic [WIDTH-1:0] next_res;
    logic [WIDTH-1:0] a_src;

    // Ripple full-adder slice over the low BPC bits of the shifting operands.
    always_comb begin
        slice_sum  = '0;
        slice_c    = '0;
        slice_c[0] = carry;
        for (int i = 0; i < BPC; i++) begin
            slice_sum[i]   = a_reg[i] ^ b_reg[i] ^ slice_c[i];
            slice_c[i + 1] = (a_reg[i] & b_reg[i]) | (slice_c[i] & (a_reg[i] ^ b_reg[i]));
        end
    end

    // New digit enters at the top of the result, older digits move toward the LSB.
    always_comb begin
        next_res = WIDTH'({slice_sum, res_reg} >> BPC);
    end

`ifdef SERIAL_ADDER_ACCUM_EN
    logic [WIDTH-1:0] acc;
    logic             unused_op_a;

    assign unused_op_a = ^op_a;

    // A clear that coincides with an accept wins, so that operation starts from zero.
    always_comb begin
        a_src = acc_clr ? '0 : acc;
    end

    // Accumulator: cleared only while idle, loaded with each delivered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (state == IDLE && acc_clr) begin
            acc <= '0;
        end else if (out_valid && out_ready) begin
            acc <= sum;
        end
    end
`else
    // Operand A comes straight from the port.
    always_comb begin
        a_src = op_a;
    end
`endif

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry     <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= a_src;
                        b_reg    <= sub ? ~op_b : op_b;
                        carry    <= sub;
                        count    <= '0;
                        res_reg  <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_reg   <= a_reg >> BPC;
                    b_reg   <= b_reg >> BPC;
                    res_reg <= next_res;
                    carry   <= slice_c[BPC];
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        sum       <= next_res;
                        carry_out <= slice_c[BPC];
                        overflow  <= slice_c[BPC] ^ slice_c[BPC-1];
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
